// File: rtl/io_input_conditioner_pkg.sv
// io_pkg: constants shared by the input-conditioning slice.
//   PORT_W         width of each in_port register seen by the bus stage
//   FLAG_OFS       bit offset of the sticky press flags inside in_port2
//   DB_CYCLES_DEF  default stable-cycle count for accepting a change
package io_pkg;
    localparam int unsigned PORT_W        = 32;
    localparam int unsigned FLAG_OFS      = 16;
    localparam int unsigned DB_CYCLES_DEF = 250000;
endpackage

// File: rtl/io_input_conditioner_if.sv
// io_input_conditioner_if: raw board inputs and conditioned input-port words.
//   sw_raw   [SW_W]   slide switches, 1 = up
//   key_raw  [KEY_W]  push buttons, active-low
//   key_ack  [KEY_W]  one-cycle pulses clearing sticky press flags
//   in_port0..2 [32]  conditioned words for the input-register stage
// Modports: master = board/bus side, slave = conditioner.
interface io_input_conditioner_if
    import io_pkg::*;
#(
    parameter int unsigned SW_W  = 10,
    parameter int unsigned KEY_W = 4
);
    logic [SW_W-1:0]   sw_raw;
    logic [KEY_W-1:0]  key_raw;
    logic [KEY_W-1:0]  key_ack;
    logic [PORT_W-1:0] in_port0;
    logic [PORT_W-1:0] in_port1;
    logic [PORT_W-1:0] in_port2;

    modport master (
        output sw_raw, key_raw, key_ack,
        input  in_port0, in_port1, in_port2
    );

    modport slave (
        input  sw_raw, key_raw, key_ack,
        output in_port0, in_port1, in_port2
    );
endinterface

// File: rtl/io_input_conditioner_debounce_bit.sv
// io_debounce_bit: 2-flop synchronizer followed by a stable-count debouncer
// for one asynchronous input bit.
//   clk, rst  clock, asynchronous active-high reset
//   raw       asynchronous input
//   db        debounced level
//   db_next   value db takes on the next rising edge (for edge detection)
// Macro IO_INPUT_DEBOUNCE_EN: when undefined the counter is left out and
// db is the synchronizer output directly.
module io_debounce_bit
    import io_pkg::*;
#(
    parameter logic        RST_VAL   = 1'b0,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic db_next
);
    logic sync1;
    logic sync2;

    if (DB_CYCLES < 2) begin : g_db_check
        $error("io_debounce_bit: DB_CYCLES must be at least 2");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef IO_INPUT_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             db_q;

    // Counter tops out at DB_CYCLES-1: the edge that would reach DB_CYCLES
    // accepts the new value and clears instead, so it can never wrap.
    always_comb begin
        cnt_next = '0;
        db_next  = db_q;
        if (sync2 != db_q) begin
            if (cnt == CNT_W'(DB_CYCLES - 1))
                db_next = sync2;
            else
                cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            db_q <= RST_VAL;
        end else begin
            cnt  <= cnt_next;
            db_q <= db_next;
        end
    end

    assign db = db_q;
`else
    assign db      = sync2;
    assign db_next = sync1;
`endif
endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronizes and debounces switches and buttons and
// presents them as three 32-bit input-port words.
//   io_clk   clock
//   reset    asynchronous active-high reset
//   bus      io_input_conditioner_if.slave (raw inputs, key_ack, in_port0..2)
// in_port0 = switches [SW_W/2-1:0], in_port1 = switches [SW_W-1:SW_W/2],
// in_port2 = key levels (1 = pressed) at [KEY_W-1:0], sticky press flags at
// [KEY_W+15:16]. Macro IO_INPUT_DEBOUNCE_EN enables the debounce counters.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int unsigned SW_W      = 10,
    parameter int unsigned KEY_W     = 4,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input logic                   io_clk,
    input logic                   reset,
    io_input_conditioner_if.slave bus
);
    localparam int unsigned HALF_W = SW_W / 2;

    logic [SW_W-1:0]   sw_db;
    logic [SW_W-1:0]   sw_db_next;
    logic [KEY_W-1:0]  key_db;       // raw polarity: 1 = released
    logic [KEY_W-1:0]  key_db_next;
    logic [KEY_W-1:0]  key_rise;
    logic [KEY_W-1:0]  flags;
    logic [PORT_W-1:0] port2;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        io_debounce_bit #(.RST_VAL(1'b0), .DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (io_clk),
            .rst     (reset),
            .raw     (bus.sw_raw[i]),
            .db      (sw_db[i]),
            .db_next (sw_db_next[i])
        );
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        io_debounce_bit #(.RST_VAL(1'b1), .DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (io_clk),
            .rst     (reset),
            .raw     (bus.key_raw[i]),
            .db      (key_db[i]),
            .db_next (key_db_next[i])
        );
    end

    // Press edge is detected from the debouncer's next value so the flag
    // sets on the same edge the debounced level changes.
    assign key_rise = key_db & ~key_db_next;

    // Set wins over a coincident ack.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset)
            flags <= '0;
        else
            flags <= (flags & ~bus.key_ack) | key_rise;
    end

    always_comb begin
        port2                      = '0;
        port2[KEY_W-1:0]           = ~key_db;
        port2[FLAG_OFS +: KEY_W]   = flags;
    end

    assign bus.in_port0 = PORT_W'(sw_db[HALF_W-1:0]);
    assign bus.in_port1 = PORT_W'(sw_db[SW_W-1:HALF_W]);
    assign bus.in_port2 = port2;

    logic unused_sw_next;
    assign unused_sw_next = ^sw_db_next;
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: directed self-checking bench for
// io_input_conditioner with SW_W = 10, KEY_W = 4, DB_CYCLES = 4.
// Works in both builds; IO_INPUT_DEBOUNCE_EN selects the expected latency
// and the glitch cases.
module tb_io_input_conditioner;
    localparam int unsigned DB = 4;
`ifdef IO_INPUT_DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 2;
`endif

    logic io_clk;
    logic reset;
    int   vectors;
    int   miscompares;

    io_input_conditioner_if #(.SW_W(10), .KEY_W(4)) bus ();

    io_input_conditioner #(.SW_W(10), .KEY_W(4), .DB_CYCLES(DB)) dut (
        .io_clk (io_clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge io_clk);
    endtask

    task automatic ack_pulse(input logic [3:0] a);
        bus.key_ack = a;
        cyc(1);
        bus.key_ack = 4'b0000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.sw_raw  = 10'h000;
        bus.key_raw = 4'b1111;
        bus.key_ack = 4'b0000;

        #12;
        check("reset_p0", bus.in_port0, 32'h0);
        check("reset_p1", bus.in_port1, 32'h0);
        check("reset_p2", bus.in_port2, 32'h0);
        @(negedge io_clk);
        reset = 1'b0;
        cyc(3);
        check("idle_p2", bus.in_port2, 32'h0);

        // All switches up: nothing before LAT edges, both halves at LAT.
        bus.sw_raw = 10'h3FF;
        cyc(LAT - 1);
        check("sw_early_p0", bus.in_port0, 32'h0);
        check("sw_early_p1", bus.in_port1, 32'h0);
        cyc(1);
        check("sw_p0", bus.in_port0, 32'h1F);
        check("sw_p1", bus.in_port1, 32'h1F);

        bus.sw_raw = 10'h2A5;
        cyc(LAT);
        check("sw2a5_p0", bus.in_port0, 32'h05);
        check("sw2a5_p1", bus.in_port1, 32'h15);
        bus.sw_raw = 10'h000;
        cyc(LAT);
        check("sw_zero_p0", bus.in_port0, 32'h0);
        check("sw_zero_p1", bus.in_port1, 32'h0);

`ifdef IO_INPUT_DEBOUNCE_EN
        // Pulse one cycle shorter than DB_CYCLES never reaches the output.
        bus.sw_raw = 10'h001;
        cyc(3);
        bus.sw_raw = 10'h000;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check("glitch3_p0", bus.in_port0, 32'h0);
        end
        // A pulse of exactly DB_CYCLES is accepted.
        bus.sw_raw = 10'h001;
        cyc(4);
        bus.sw_raw = 10'h000;
        cyc(2);
        check("pulse4_p0", bus.in_port0, 32'h1);
        cyc(LAT);
        check("pulse4_end_p0", bus.in_port0, 32'h0);
`else
        // Without debouncing a one-cycle glitch passes straight through.
        bus.sw_raw = 10'h001;
        cyc(1);
        bus.sw_raw = 10'h000;
        cyc(1);
        check("glitch1_p0", bus.in_port0, 32'h1);
        cyc(1);
        check("glitch1_end_p0", bus.in_port0, 32'h0);
`endif

        // Key 2 press sets level and flag together; release keeps the flag.
        bus.key_raw = 4'b1011;
        cyc(LAT - 1);
        check("key2_early", bus.in_port2, 32'h0);
        cyc(1);
        check("key2_press", bus.in_port2, 32'h00040004);
        bus.key_raw = 4'b1111;
        cyc(LAT - 1);
        check("key2_rel_early", bus.in_port2, 32'h00040004);
        cyc(1);
        check("key2_release", bus.in_port2, 32'h00040000);

        ack_pulse(4'b0100);
        check("ack_clear", bus.in_port2, 32'h0);

        // Ack landing on the same edge as a new press: flag stays set.
        bus.key_raw = 4'b1011;
        cyc(LAT - 1);
        ack_pulse(4'b0100);
        check("ack_vs_set", bus.in_port2, 32'h00040004);
        bus.key_raw = 4'b1111;
        cyc(LAT);
        check("key2_release2", bus.in_port2, 32'h00040000);
        ack_pulse(4'b0100);
        check("ack_clear2", bus.in_port2, 32'h0);
        ack_pulse(4'b0010);
        check("ack_on_clear", bus.in_port2, 32'h0);

        // Three keys, then multi-bit ack.
        bus.key_raw = 4'b1000;
        cyc(LAT);
        check("key012_press", bus.in_port2, 32'h00070007);
        bus.key_raw = 4'b1111;
        cyc(LAT);
        check("key012_release", bus.in_port2, 32'h00070000);
        ack_pulse(4'b0011);
        check("ack_multi", bus.in_port2, 32'h00040000);
        ack_pulse(4'b0100);
        check("ack_last", bus.in_port2, 32'h0);

        // Reset part way through a change discards the partial count.
        bus.sw_raw = 10'h3FF;
        cyc(3);
        #2 reset = 1'b1;
        #1 check("rst_mid_p0", bus.in_port0, 32'h0);
        @(negedge io_clk);
        reset = 1'b0;
        cyc(LAT - 1);
        check("rst_restart_early", bus.in_port0, 32'h0);
        cyc(1);
        check("rst_restart_p0", bus.in_port0, 32'h1F);

        // Asynchronous reset clears every output between clock edges.
        bus.key_raw = 4'b0111;
        cyc(LAT);
        check("key3_press", bus.in_port2, 32'h00080008);
        #2 reset = 1'b1;
        #1;
        check("async_rst_p0", bus.in_port0, 32'h0);
        check("async_rst_p1", bus.in_port1, 32'h0);
        check("async_rst_p2", bus.in_port2, 32'h0);
        @(negedge io_clk);
        bus.key_raw = 4'b1111;
        bus.sw_raw  = 10'h000;
        reset       = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/io_input_conditioner.md
IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 Parameter SW_W, default 10, number of slide-switch inputs (even, 2..32).
REQ-002 Parameter KEY_W, default 4, number of push-button inputs (1..15).
REQ-003 Parameter DB_CYCLES, default 250000, stable-cycle count required to accept a change (>=2).
REQ-004 io_clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sw_raw  input  SW_W  asynchronous switch levels, 1 = up.
REQ-007 key_raw  input  KEY_W  asynchronous buttons, active-low (0 = pressed).
REQ-008 key_ack  input  KEY_W  one-cycle pulse per bit; clears the matching sticky press flag.
REQ-009 in_port0  output  32  zero-extended debounced sw[SW_W/2-1:0].
REQ-010 in_port1  output  32  zero-extended debounced sw[SW_W-1:SW_W/2].
REQ-011 in_port2  output  32  bits[KEY_W-1:0] = debounced key level (1 = pressed); bits[KEY_W+15:16] = sticky press flags; all other bits 0.

Function
REQ-012 Every raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Per bit, a counter SHALL increment each cycle the synchronized value differs from the debounced value and SHALL clear when they match.
REQ-014 The debounced value SHALL take the synchronized value on the edge where the counter would reach DB_CYCLES; the counter clears on that same edge.
REQ-015 Latency: a raw change held stable SHALL appear on the outputs exactly DB_CYCLES+2 cycles after first sampled; a glitch shorter than DB_CYCLES cycles SHALL never appear.
REQ-016 Counter width SHALL be $clog2(DB_CYCLES+1); the counter SHALL never wrap.
REQ-017 A sticky flag SHALL set on the edge where its debounced key goes released->pressed; release SHALL not affect it.
REQ-018 key_ack SHALL clear its flag on the next edge; simultaneous set and ack on the same bit SHALL leave the flag set.
REQ-019 key_ack on a clear flag SHALL have no effect; acks on multiple bits in one cycle SHALL all apply.
REQ-020 All outputs SHALL be registered or pure wiring of registered state; no combinational path from any input to any output.

Reset
REQ-021 On reset assertion, synchronizer and debounced switch state SHALL go to 0 immediately, key synchronizer and debounced key state to released, all counters and flags to 0.
REQ-022 Reset values: in_port0 = in_port1 = in_port2 = 0x00000000.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; after deassertion, counting restarts from 0.

Configuration
REQ-024 Macro IO_INPUT_DEBOUNCE_EN defined: counters present, behaviour per REQ-013..016.
REQ-025 Macro absent: no counters; debounced value = synchronized value; latency exactly 2 cycles; DB_CYCLES ignored; flag and reset behaviour unchanged.

Structure
REQ-026 Shared package io_pkg SHALL hold the 32-bit port width constant, the in_port2 flag offset (16) and the default DB_CYCLES.
REQ-027 Sub-module io_debounce_bit (one synchronizer + counter + debounced flop, parameterised on reset value) SHALL be instantiated once per switch and key bit.
REQ-028 Outputs connect directly to in_port0..2 of the existing input-register stage; address decoding stays in that stage.

Verification (DB_CYCLES = 4, SW_W = 10, KEY_W = 4)
REQ-029 Reset, then sw_raw = 10'h3FF held -> in_port0 = 0x1F and in_port1 = 0x1F exactly 6 cycles after first sample edge; 0 before.
REQ-030 sw_raw[0] pulses high for 3 cycles -> in_port0 stays 0x00000000 throughout.
REQ-031 key_raw[2] driven low and held -> in_port2 = 0x00040004 after 6 cycles; release -> 0x00040000 after 6 more cycles.
REQ-032 key_ack = 4'b0100 pulse with flag set -> in_port2[18] = 0 next cycle; ack coincident with new press edge -> flag remains 1.
REQ-033 Reset asserted after 3 stable cycles of a change -> outputs 0 asynchronously; after release, a full 6 cycles are needed again.
REQ-034 Build without IO_INPUT_DEBOUNCE_EN: sw_raw = 10'h001 -> in_port0 = 0x1 after 2 cycles; 1-cycle glitch passes through.
